uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Controller and buffer in front of uart_rx.
- Latches the baud/parity configuration and sequences uart_rx's enable through a small FSM.
- Captures received bytes into a show-ahead FIFO drained over a valid/ready port.
- Maintains sticky overrun/parity error flags, a character-timeout flag and a combined interrupt.

Parameters:
FIFO_DEPTH, 16, RX FIFO entries; power of two, >=2
TIMEOUT_TICKS, 40, baud ticks without FIFO activity before timeout (40 = four 10-bit chars)

Ports:
clk  in  1  clock
rstn_i  in  1  reset
cfg_enable_i  in  1  software receive enable (level)
cfg_clk_div_i  in  32  baud divider requested
cfg_parity_en_i  in  1  parity enable requested
cfg_irq_thresh_i  in  LW  FIFO level interrupt threshold; 0 disables; LW=$clog2(FIFO_DEPTH)+1
flush_i  in  1  one-cycle pulse: empty FIFO
err_clr_i  in  1  one-cycle pulse: clear sticky flags
rx_enable_o  out  1  to uart_rx rx_enable_i
rx_clk_div_o  out  32  to uart_rx clk_div_i
rx_parity_en_o  out  1  to uart_rx parity_en_i
rx_data_i  in  8  from uart_rx rx_data_o
rx_valid_i  in  1  from uart_rx rx_valid_o (one-cycle pulse)
rx_err_i  in  1  from uart_rx rx_err_o
data_o  out  8  FIFO head
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer pop
level_o  out  LW  FIFO occupancy 0..FIFO_DEPTH
overrun_o  out  1  sticky: byte dropped, FIFO full
parity_err_o  out  1  sticky: byte received with rx_err_i
timeout_o  out  1  character timeout pending
irq_o  out  1  combined interrupt

Behaviour:
- Clock and reset:
  - One clock (clk); reset (rstn_i) is asynchronous and active-low.
  - Reset values: all outputs 0; FIFO empty; state OFF; counters 0.
- FSM states: OFF, CFG, RUN.
  - OFF: rx_enable_o=0. Goes to CFG when cfg_enable_i=1.
  - CFG: one cycle. rx_enable_o=0. Latches cfg_clk_div_i into rx_clk_div_o and cfg_parity_en_i into rx_parity_en_o. Goes to RUN unconditionally.
  - RUN: rx_enable_o=1. Goes to OFF in the cycle after cfg_enable_i=0, so rx_enable_o drops 1 cycle after the deassert. That aborts any in-flight frame in uart_rx.
  - rx_clk_div_o and rx_parity_en_o change only in CFG. Config changes during RUN take effect only after OFF->CFG.
  - FIFO contents and sticky flags persist across OFF; reads are allowed in any state.
- Capture:
  - rx_valid_i is accepted only in RUN; in OFF/CFG it is ignored entirely.
  - Push data = rx_data_i.
  - rx_valid_i=1 with rx_err_i=1: byte still pushed and parity_err_o set.
- FIFO:
  - valid_o=(level_o!=0); data_o = head entry.
  - A pop occurs when valid_o & ready_i.
  - Push at edge N: valid_o/level_o/data_o (when previously empty) update after edge N. Latency 1 cycle.
  - Full, push and pop in same cycle: both occur, level unchanged, no overrun.
  - Full, push, no pop: byte dropped, overrun_o set, level stays FIFO_DEPTH.
  - Empty: ready_i ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - flush_i: level->0 next cycle, timeout_o cleared. A push or pop in the same cycle is discarded. Sticky flags are unaffected.
- Sticky flags:
  - err_clr_i clears overrun_o and parity_err_o.
  - A set event in the same cycle as err_clr_i wins (flag stays 1).
- Timeout:
  - Prescaler counts 0..rx_clk_div_o and emits a tick on wrap; it runs only in RUN.
  - Tick counter counts ticks, saturating at TIMEOUT_TICKS.
  - Prescaler and tick counter reset on any push, pop, flush_i, or when not in RUN.
  - When the tick counter reaches TIMEOUT_TICKS and level_o!=0: timeout_o=1.
  - timeout_o clears on pop, flush_i, or when level becomes 0.
- irq_o (combinational from registered state):
  - irq_o = (thresh!=0 & level_o>=thresh) | timeout_o | overrun_o | parity_err_o.
  - thresh > FIFO_DEPTH: level term never fires.

Test Plan:
- Enable sequencing: cfg_enable_i=1, cfg_clk_div_i=433, parity=1. Then change cfg_clk_div_i to 99 during RUN -> rx_enable_o rises 2 cycles after enable; rx_clk_div_o=433, rx_parity_en_o=1 held. cfg_enable_i=0 -> rx_enable_o=0 next cycle. Re-enable -> rx_clk_div_o=99.
- Ordering/latency: push 0xA5,0x3C,0xFF with ready_i=0, then ready_i=1 -> valid_o 1 cycle after first push; level_o 1,2,3; data_o pops A5,3C,FF; valid_o=0 after the third pop.
- Full boundary (depth 16): push 16 bytes -> level_o=16. 17th push with no pop -> dropped, overrun_o=1. Push+pop same cycle when full -> level_o=16, correct order. err_clr_i simultaneous with a new overrun -> overrun_o stays 1.
- Error/ignore: rx_valid_i with rx_err_i=1 -> byte stored, parity_err_o=1, irq_o=1. rx_valid_i while OFF -> level_o unchanged.
- Timeout: clk_div=3, one byte pushed, no pop -> timeout_o=1 after 40 ticks (160 cycles). A pop clears it. With FIFO empty, no timeout ever fires.
- Threshold/flush: thresh=4, push 4 bytes -> irq_o=1 when level_o=4. flush_i with simultaneous rx_valid_i -> level_o=0, irq_o=0, pushed byte absent. Reset mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: controller and receive buffer in front of uart_rx.
//   - Sequences uart_rx enable through OFF -> CFG -> RUN and latches the
//     baud divider / parity setting only in CFG.
//   - Buffers received bytes in a show-ahead FIFO drained over valid/ready.
//   - Sticky overrun / parity flags, character timeout, combined irq.
// Ports:
//   clk, rstn_i                         clock, async active-low reset
//   cfg_enable_i, cfg_clk_div_i,
//   cfg_parity_en_i, cfg_irq_thresh_i   software configuration
//   flush_i, err_clr_i                  one-cycle command pulses
//   rx_enable_o, rx_clk_div_o,
//   rx_parity_en_o                      to uart_rx
//   rx_data_i, rx_valid_i, rx_err_i     from uart_rx
//   data_o, valid_o, ready_i, level_o   FIFO read port / occupancy
//   overrun_o, parity_err_o, timeout_o,
//   irq_o                               status and interrupt
module uart_rx_ctrl #(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int TIMEOUT_TICKS = 40,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn_i,
    input  logic          cfg_enable_i,
    input  logic [31:0]   cfg_clk_div_i,
    input  logic          cfg_parity_en_i,
    input  logic [LW-1:0] cfg_irq_thresh_i,
    input  logic          flush_i,
    input  logic          err_clr_i,
    output logic          rx_enable_o,
    output logic [31:0]   rx_clk_div_o,
    output logic          rx_parity_en_o,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          rx_err_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [LW-1:0] level_o,
    output logic          overrun_o,
    output logic          parity_err_o,
    output logic          timeout_o,
    output logic          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {S_OFF, S_CFG, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [31:0]     presc_q;
    logic [TW-1:0]   tick_cnt_q;
    logic            overrun_q, parity_err_q, timeout_q;

    logic run, push_req, full, do_push, do_pop, drop;
    logic cnt_clr, tick, to_hit;

    // ---------------- enable sequencing ----------------
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_OFF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        rx_enable_o = 1'b0;
        case (state_q)
            S_OFF: if (cfg_enable_i) state_d = S_CFG;
            S_CFG: state_d = S_RUN;
            S_RUN: begin
                rx_enable_o = 1'b1;
                if (!cfg_enable_i) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Configuration is sampled only on the way into RUN so uart_rx never
    // sees a divider change mid-frame.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_clk_div_o   <= '0;
            rx_parity_en_o <= 1'b0;
        end else if (state_q == S_CFG) begin
            rx_clk_div_o   <= cfg_clk_div_i;
            rx_parity_en_o <= cfg_parity_en_i;
        end
    end

    // ---------------- capture / FIFO ----------------
    assign run      = (state_q == S_RUN);
    assign push_req = run & rx_valid_i;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign valid_o  = (level_q != '0);
    // Flush discards any same-cycle push or pop.
    assign do_pop   = valid_o & ready_i & ~flush_i;
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push  = push_req & ~flush_i & (~full | do_pop);
    assign drop     = push_req & ~flush_i & full & ~do_pop;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= rx_data_i;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr_q];
    assign level_o = level_q;

    // ---------------- sticky flags ----------------
    // Set terms are OR'ed after the clear so a same-cycle event wins.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overrun_q    <= drop | (overrun_q & ~err_clr_i);
            parity_err_q <= (push_req & rx_err_i) | (parity_err_q & ~err_clr_i);
        end
    end

    // ---------------- character timeout ----------------
    assign cnt_clr = do_push | do_pop | flush_i | ~run;
    assign tick    = (presc_q == rx_clk_div_o);
    // Fire in the same edge the tick counter reaches its limit.
    assign to_hit  = ~cnt_clr & ((tick_cnt_q == TW'(TIMEOUT_TICKS)) |
                                 (tick & (tick_cnt_q == TW'(TIMEOUT_TICKS - 1))));

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q    <= '0;
            tick_cnt_q <= '0;
        end else if (cnt_clr) begin
            presc_q    <= '0;
            tick_cnt_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            if (tick_cnt_q != TW'(TIMEOUT_TICKS)) tick_cnt_q <= tick_cnt_q + 1'b1;
        end else begin
            presc_q <= presc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)                        timeout_q <= 1'b0;
        else if (do_pop || flush_i)         timeout_q <= 1'b0;
        else if (level_q == '0)             timeout_q <= 1'b0;
        else if (to_hit)                    timeout_q <= 1'b1;
    end

    assign overrun_o    = overrun_q;
    assign parity_err_o = parity_err_q;
    assign timeout_o    = timeout_q;

    // Thresholds above FIFO_DEPTH can never be reached by level_q.
    assign irq_o = ((cfg_irq_thresh_i != '0) && (level_q >= cfg_irq_thresh_i)) |
                   timeout_q | overrun_q | parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn_i;
    logic          cfg_enable_i;
    logic [31:0]   cfg_clk_div_i;
    logic          cfg_parity_en_i;
    logic [LW-1:0] cfg_irq_thresh_i;
    logic          flush_i;
    logic          err_clr_i;
    logic          rx_enable_o;
    logic [31:0]   rx_clk_div_o;
    logic          rx_parity_en_o;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_err_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          ready_i;
    logic [LW-1:0] level_o;
    logic          overrun_o;
    logic          parity_err_o;
    logic          timeout_o;
    logic          irq_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_TICKS(40)) dut (
        .clk              (clk),
        .rstn_i           (rstn_i),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_clk_div_i    (cfg_clk_div_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_irq_thresh_i (cfg_irq_thresh_i),
        .flush_i          (flush_i),
        .err_clr_i        (err_clr_i),
        .rx_enable_o      (rx_enable_o),
        .rx_clk_div_o     (rx_clk_div_o),
        .rx_parity_en_o   (rx_parity_en_o),
        .rx_data_i        (rx_data_i),
        .rx_valid_i       (rx_valid_i),
        .rx_err_i         (rx_err_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .level_o          (level_o),
        .overrun_o        (overrun_o),
        .parity_err_o     (parity_err_o),
        .timeout_o        (timeout_o),
        .irq_o            (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic err);
        rx_data_i  = d;
        rx_err_i   = err;
        rx_valid_i = 1'b1;
        step();
        rx_valid_i = 1'b0;
        rx_err_i   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   32'(rx_enable_o), 0);
        chk({tag, "_div"},  rx_clk_div_o, 0);
        chk({tag, "_par"},  32'(rx_parity_en_o), 0);
        chk({tag, "_data"}, 32'(data_o), 0);
        chk({tag, "_vld"},  32'(valid_o), 0);
        chk({tag, "_lvl"},  32'(level_o), 0);
        chk({tag, "_ovr"},  32'(overrun_o), 0);
        chk({tag, "_perr"}, 32'(parity_err_o), 0);
        chk({tag, "_to"},   32'(timeout_o), 0);
        chk({tag, "_irq"},  32'(irq_o), 0);
    endtask

    logic [7:0] drain_exp [16];

    initial begin
        rstn_i = 1'b0; cfg_enable_i = 1'b0; cfg_clk_div_i = '0; cfg_parity_en_i = 1'b0;
        cfg_irq_thresh_i = '0; flush_i = 1'b0; err_clr_i = 1'b0;
        rx_data_i = '0; rx_valid_i = 1'b0; rx_err_i = 1'b0; ready_i = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");

        // ---- enable sequencing ----
        rstn_i = 1'b1; cfg_enable_i = 1'b1; cfg_clk_div_i = 32'd433; cfg_parity_en_i = 1'b1;
        step();
        chk("en_cfg_cycle", 32'(rx_enable_o), 0);
        step();
        chk("en_run", 32'(rx_enable_o), 1);
        chk("div_433", rx_clk_div_o, 433);
        chk("par_1", 32'(rx_parity_en_o), 1);
        cfg_clk_div_i = 32'd99; cfg_parity_en_i = 1'b0;
        step();
        chk("div_held", rx_clk_div_o, 433);
        chk("par_held", 32'(rx_parity_en_o), 1);
        cfg_enable_i = 1'b0;
        step();
        chk("en_drop", 32'(rx_enable_o), 0);
        cfg_enable_i = 1'b1;
        step(); step();
        chk("re_en", 32'(rx_enable_o), 1);
        chk("div_99", rx_clk_div_o, 99);
        chk("par_0", 32'(rx_parity_en_o), 0);

        // ---- ordering / latency ----
        push(8'hA5, 1'b0);
        chk("ord_vld1", 32'(valid_o), 1);
        chk("ord_lvl1", 32'(level_o), 1);
        chk("ord_head1", 32'(data_o), 32'hA5);
        push(8'h3C, 1'b0);
        chk("ord_lvl2", 32'(level_o), 2);
        chk("ord_head2", 32'(data_o), 32'hA5);
        push(8'hFF, 1'b0);
        chk("ord_lvl3", 32'(level_o), 3);
        ready_i = 1'b1;
        step();
        chk("ord_pop1", 32'(data_o), 32'h3C);
        chk("ord_lvl_p1", 32'(level_o), 2);
        step();
        chk("ord_pop2", 32'(data_o), 32'hFF);
        step();
        chk("ord_empty", 32'(valid_o), 0);
        chk("ord_lvl0", 32'(level_o), 0);
        ready_i = 1'b0;

        // ---- full boundary ----
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
        chk("full_lvl", 32'(level_o), 16);
        chk("full_no_ovr", 32'(overrun_o), 0);
        push(8'hEE, 1'b0);
        chk("ovr_lvl", 32'(level_o), 16);
        chk("ovr_set", 32'(overrun_o), 1);
        chk("ovr_irq", 32'(irq_o), 1);
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        chk("ovr_clr", 32'(overrun_o), 0);
        chk("ovr_clr_irq", 32'(irq_o), 0);
        ready_i = 1'b1;
        push(8'h77, 1'b0);
        ready_i = 1'b0;
        chk("pp_lvl", 32'(level_o), 16);
        chk("pp_head", 32'(data_o), 32'h11);
        chk("pp_no_ovr", 32'(overrun_o), 0);
        err_clr_i = 1'b1;
        push(8'h88, 1'b0);
        err_clr_i = 1'b0;
        chk("ovr_wins_clr", 32'(overrun_o), 1);
        for (int i = 0; i < 15; i++) drain_exp[i] = 8'(8'h11 + i);
        drain_exp[15] = 8'h77;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(data_o), 32'(drain_exp[i]));
            ready_i = 1'b1;
            step();
        end
        ready_i = 1'b0;
        chk("drain_lvl0", 32'(level_o), 0);
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        chk("ovr_clr2", 32'(overrun_o), 0);

        // ---- parity error / ignore while off ----
        push(8'h5A, 1'b1);
        chk("perr_lvl", 32'(level_o), 1);
        chk("perr_data", 32'(data_o), 32'h5A);
        chk("perr_set", 32'(parity_err_o), 1);
        chk("perr_irq", 32'(irq_o), 1);
        ready_i = 1'b1; step(); ready_i = 1'b0;
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        chk("perr_clr", 32'(parity_err_o), 0);
        chk("perr_clr_irq", 32'(irq_o), 0);
        cfg_enable_i = 1'b0;
        step();
        chk("off_en", 32'(rx_enable_o), 0);
        push(8'h99, 1'b1);
        chk("off_ignore_lvl", 32'(level_o), 0);
        chk("off_ignore_perr", 32'(parity_err_o), 0);

        // ---- timeout ----
        cfg_clk_div_i = 32'd3; cfg_enable_i = 1'b1;
        step(); step();
        chk("to_div3", rx_clk_div_o, 3);
        repeat (200) step();
        chk("to_empty_none", 32'(timeout_o), 0);
        push(8'h42, 1'b0);
        repeat (159) step();
        chk("to_before", 32'(timeout_o), 0);
        step();
        chk("to_fire", 32'(timeout_o), 1);
        chk("to_irq", 32'(irq_o), 1);
        ready_i = 1'b1; step(); ready_i = 1'b0;
        chk("to_pop_clr", 32'(timeout_o), 0);
        chk("to_pop_lvl", 32'(level_o), 0);

        // ---- threshold / flush ----
        cfg_irq_thresh_i = LW'(4);
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
        chk("th_below", 32'(irq_o), 0);
        push(8'h04, 1'b0);
        chk("th_lvl4", 32'(level_o), 4);
        chk("th_irq", 32'(irq_o), 1);
        flush_i = 1'b1;
        push(8'hDD, 1'b0);
        flush_i = 1'b0;
        chk("fl_lvl", 32'(level_o), 0);
        chk("fl_vld", 32'(valid_o), 0);
        chk("fl_irq", 32'(irq_o), 0);
        push(8'h33, 1'b0);
        chk("fl_after_data", 32'(data_o), 32'h33);
        chk("fl_after_lvl", 32'(level_o), 1);

        // ---- asynchronous reset mid-RUN ----
        #2;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("rst_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
